// File: rtl/arc_pkg.sv
// Shared definitions for the ARC MIPS fetch stage: FSM state encoding and PC constants.
package arc_pkg;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC               = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/if_pcadd4.sv
// Fetch-side PC+4 incrementer, the counterpart of the EX branch adder; wraps modulo 2^32.
module if_pcadd4
  import arc_pkg::*;
(
  input  logic [31:0] pc,
  output logic [31:0] pc_add4
);

  assign pc_add4 = pc + PC_INC;

endmodule

// File: rtl/if_pc_fetch.sv
// Fetch-stage PC unit: holds PC, issues imem requests with valid/ready, buffers
// redirects that arrive while a request is outstanding, and flags the wrong-path fetch.
module if_pc_fetch
  import arc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en_stallF,
  input  logic        i_sel_pcsrcE,
  input  logic [31:0] i_addr_pcbranchE,
  input  logic        i_sel_jumpD,
  input  logic [31:0] i_addr_jumpD,
  input  logic        i_ready_imemF,
  output logic        o_valid_imemF,
  output logic [31:0] o_addr_pcF,
  output logic [31:0] o_addr_pcadd4F,
  output logic        o_en_fireF,
  output logic        o_flag_killF,
  output logic        o_flag_misalignF
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic         pend_valid, pend_valid_next;
  logic [31:0]  pend_addr, pend_addr_next;
  logic [31:0]  pc_add4;
  logic         redirect_live;
  logic [31:0]  redirect_tgt;
  logic         pc_load;
  logic         fire;

  if_pcadd4 u_pcadd4 (
    .pc      (pc),
    .pc_add4 (pc_add4)
  );

  // A resolved branch is older than a decoded jump, so it takes priority.
  assign redirect_live = i_sel_pcsrcE | i_sel_jumpD;
  assign redirect_tgt  = i_sel_pcsrcE ? i_addr_pcbranchE : i_addr_jumpD;

  assign o_valid_imemF    = (state == RUN);
  assign fire             = o_valid_imemF & i_ready_imemF & ~i_en_stallF;
  assign o_en_fireF       = fire;
  assign o_flag_killF     = fire & pend_valid;
  assign o_flag_misalignF = (state == HALT);
  assign o_addr_pcF       = pc;
  assign o_addr_pcadd4F   = pc_add4;

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    pend_valid_next = pend_valid;
    pend_addr_next  = pend_addr;
    pc_load         = 1'b0;

    unique case (state)
      RST: begin
        state_next = RUN;
        if (redirect_live) begin
          pc_next = redirect_tgt;
          pc_load = 1'b1;
        end
      end
      RUN: begin
        if (fire) begin
          pc_load         = 1'b1;
          pend_valid_next = 1'b0;
          if (i_sel_pcsrcE)     pc_next = i_addr_pcbranchE;
          else if (pend_valid)  pc_next = pend_addr;
          else if (i_sel_jumpD) pc_next = i_addr_jumpD;
          else                  pc_next = pc_add4;
        end else if (i_sel_pcsrcE) begin
          pend_valid_next = 1'b1;
          pend_addr_next  = i_addr_pcbranchE;
        end else if (i_sel_jumpD && !pend_valid) begin
          // An already-held target is older than this jump and must survive.
          pend_valid_next = 1'b1;
          pend_addr_next  = i_addr_jumpD;
        end
      end
      HALT: begin
        if (redirect_live) begin
          pc_next    = redirect_tgt;
          pc_load    = 1'b1;
          state_next = RUN;
        end
      end
      default: begin
        state_next = RST;
      end
    endcase

    if (pc_load && (pc_next[1:0] != 2'b00)) begin
      state_next = HALT;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= RST;
      pc         <= RESET_VECTOR;
      pend_valid <= 1'b0;
      pend_addr  <= 32'd0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pend_valid <= pend_valid_next;
      pend_addr  <= pend_addr_next;
    end
  end

endmodule

// File: tb/tb_if_pc_fetch.sv
// Directed self-checking bench for if_pc_fetch; expected values are hand-computed per step.
module tb_if_pc_fetch;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_en_stallF;
  logic        i_sel_pcsrcE;
  logic [31:0] i_addr_pcbranchE;
  logic        i_sel_jumpD;
  logic [31:0] i_addr_jumpD;
  logic        i_ready_imemF;
  logic        o_valid_imemF;
  logic [31:0] o_addr_pcF;
  logic [31:0] o_addr_pcadd4F;
  logic        o_en_fireF;
  logic        o_flag_killF;
  logic        o_flag_misalignF;

  int tests_run;
  int tests_failed;

  if_pc_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_en_stallF      (i_en_stallF),
    .i_sel_pcsrcE     (i_sel_pcsrcE),
    .i_addr_pcbranchE (i_addr_pcbranchE),
    .i_sel_jumpD      (i_sel_jumpD),
    .i_addr_jumpD     (i_addr_jumpD),
    .i_ready_imemF    (i_ready_imemF),
    .o_valid_imemF    (o_valid_imemF),
    .o_addr_pcF       (o_addr_pcF),
    .o_addr_pcadd4F   (o_addr_pcadd4F),
    .o_en_fireF       (o_en_fireF),
    .o_flag_killF     (o_flag_killF),
    .o_flag_misalignF (o_flag_misalignF)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Inputs are driven just after the falling edge; outputs settle 1 time unit later.
  task automatic applyStimulus(input logic br, input logic [31:0] bt, input logic jp,
                               input logic [31:0] jt, input logic rdy, input logic stall);
    i_sel_pcsrcE     = br;
    i_addr_pcbranchE = bt;
    i_sel_jumpD      = jp;
    i_addr_jumpD     = jt;
    i_ready_imemF    = rdy;
    i_en_stallF      = stall;
    #1;
  endtask

  task automatic checkFetch(input string tag, input logic valid, input logic [31:0] addr,
                            input logic fire, input logic kill);
    checkOutput({tag, ".valid"}, {31'd0, o_valid_imemF}, {31'd0, valid});
    checkOutput({tag, ".addr"},  o_addr_pcF, addr);
    checkOutput({tag, ".fire"},  {31'd0, o_en_fireF}, {31'd0, fire});
    checkOutput({tag, ".kill"},  {31'd0, o_flag_killF}, {31'd0, kill});
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_rst_n      = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    tick();

    // Reset values while reset is held
    checkFetch("rst", 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("rst.add4", o_addr_pcadd4F, 32'h4);
    checkOutput("rst.misalign", {31'd0, o_flag_misalignF}, 32'd0);

    // Release: one RST cycle, then sequential fetches 0x0, 0x4, 0x8
    i_rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkFetch("cyc1", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkFetch("seq0", 1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    checkFetch("seq4", 1'b1, 32'h4, 1'b1, 1'b0);
    tick();
    checkFetch("seq8", 1'b1, 32'h8, 1'b1, 1'b0);
    checkOutput("seq8.add4", o_addr_pcadd4F, 32'hC);
    tick();
    checkFetch("seqC", 1'b1, 32'hC, 1'b1, 1'b0);
    tick();

    // Branch arrives while imem is not ready: buffered, PC held, kill on fire
    applyStimulus(1'b1, 32'h200, 1'b0, 32'd0, 1'b0, 1'b0);
    checkFetch("bufbr0", 1'b1, 32'h10, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkFetch("bufbr1", 1'b1, 32'h10, 1'b0, 1'b0);
    tick();
    checkFetch("bufbr2", 1'b1, 32'h10, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkFetch("bufbr.fire", 1'b1, 32'h10, 1'b1, 1'b1);
    tick();
    checkFetch("bufbr.tgt", 1'b1, 32'h200, 1'b1, 1'b0);
    tick();

    // Simultaneous branch and jump at fire: branch wins
    applyStimulus(1'b1, 32'h300, 1'b1, 32'h400, 1'b1, 1'b0);
    checkFetch("prio.fire", 1'b1, 32'h204, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h300, 1'b0, 32'd0, 1'b0, 1'b0);
    checkFetch("prio.tgt", 1'b1, 32'h300, 1'b0, 1'b0);
    tick();
    // A later jump must not displace the held branch target
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h500, 1'b0, 1'b0);
    checkFetch("pendj", 1'b1, 32'h300, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkFetch("pendj.fire", 1'b1, 32'h300, 1'b1, 1'b1);
    tick();
    checkFetch("pendj.tgt", 1'b1, 32'h300, 1'b1, 1'b0);
    tick();

    // Stall with ready high blocks fire; dropping it advances to PC+4
    applyStimulus(1'b1, 32'h20, 1'b0, 32'd0, 1'b1, 1'b0);
    checkFetch("tostall", 1'b1, 32'h304, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    checkFetch("stall0", 1'b1, 32'h20, 1'b0, 1'b0);
    tick();
    checkFetch("stall1", 1'b1, 32'h20, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkFetch("unstall", 1'b1, 32'h20, 1'b1, 1'b0);
    tick();
    checkFetch("unstall.nxt", 1'b1, 32'h24, 1'b1, 1'b0);

    // Misaligned branch target halts fetch until an aligned redirect
    applyStimulus(1'b1, 32'h102, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkFetch("halt0", 1'b0, 32'h102, 1'b0, 1'b0);
    checkOutput("halt0.misalign", {31'd0, o_flag_misalignF}, 32'd1);
    tick();
    checkOutput("halt1.misalign", {31'd0, o_flag_misalignF}, 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h40, 1'b1, 1'b0);
    checkFetch("halt1", 1'b0, 32'h102, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("resume.misalign", {31'd0, o_flag_misalignF}, 32'd0);
    checkFetch("resume", 1'b1, 32'h40, 1'b1, 1'b0);

    // PC+4 wraps at the top of the address space
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("wrap.pc", o_addr_pcF, 32'hFFFF_FFFC);
    checkOutput("wrap.add4", o_addr_pcadd4F, 32'h0);
    tick();
    checkFetch("wrap.nxt", 1'b1, 32'h0, 1'b1, 1'b0);
    tick();

    // Reset mid-request drops the request and the buffered redirect
    applyStimulus(1'b1, 32'h800, 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    #1;
    i_rst_n = 1'b0;
    #1;
    checkFetch("midrst", 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    checkFetch("postrst", 1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    checkFetch("postrst.nxt", 1'b1, 32'h4, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_pc_fetch.md
# if_pc_fetch

Fetch-stage program-counter unit of the ARC MIPS pipeline. Holds PC, drives the instruction-memory request with a valid/ready handshake, and produces PC+4 for the IF/ID register. Selects the next PC from sequential PC+4, the D-stage jump target, or the E-stage branch target (o_addr_pcbranchE of the EX branch adder, driven when the branch resolves taken). Redirects that arrive while a request is outstanding are buffered, and the wrong-path fetch is marked for squash.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value after reset; must be word-aligned
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_en_stallF  input  1  hazard-unit stall; PC must not advance
- i_sel_pcsrcE  input  1  taken branch resolved in EX
- i_addr_pcbranchE  input  32  branch target from EX
- i_sel_jumpD  input  1  jump decoded in ID
- i_addr_jumpD  input  32  jump target from ID
- i_ready_imemF  input  1  instruction memory accepts request
- o_valid_imemF  output  1  fetch request valid
- o_addr_pcF  output  32  current PC / imem address
- o_addr_pcadd4F  output  32  PC+4 to IF/ID
- o_en_fireF  output  1  request accepted this cycle; IF/ID captures
- o_flag_killF  output  1  accepted fetch is wrong-path; IF/ID loads bubble
- o_flag_misalignF  output  1  PC[1:0] != 0; fetch halted

## Operation
- States: RST (one cycle after reset release, valid low), RUN (valid high), HALT (misaligned PC, valid low).
- Live redirect: branch = i_sel_pcsrcE with target i_addr_pcbranchE; otherwise jump = i_sel_jumpD with target i_addr_jumpD. Branch wins when both are asserted.
- Fire: o_en_fireF = o_valid_imemF & i_ready_imemF & !i_en_stallF.
- Address stability: while o_valid_imemF is high, o_addr_pcF holds until fire. A stalled request stays presented, and imem re-reads are idempotent.
- RUN, fire cycle: the next PC is chosen in this order:
  - live branch target, if a branch is asserted;
  - otherwise the pending target, if one is held;
  - otherwise the live jump target, if a jump is asserted;
  - otherwise PC+4.
  - The pending register clears.
  - o_flag_killF = pending held at fire.
- RUN, no-fire cycle with a live redirect: capture into pending.
  - A branch overwrites any pending entry.
  - A jump only fills an empty pending entry.
  - PC is unchanged.
- RST and HALT with a live redirect: PC loads the target directly, because no request is outstanding.
- A live redirect overrides i_en_stallF for capture and load, but a fire still requires no stall.
- RST → RUN unconditionally next cycle; PC is unchanged unless a redirect loads it.
- Any PC load whose value has [1:0] != 0: PC takes the value and the state goes to HALT.
  - o_flag_misalignF = state HALT.
  - HALT → RUN on a live redirect with an aligned target; a misaligned target stays in HALT with the new PC.
- Arithmetic: o_addr_pcadd4F = PC + 32'd4, modulo 2^32, so 32'hFFFF_FFFC gives 32'h0000_0000.

## Timing
- Reset (async assert, sync release): PC = RESET_VECTOR, state RST, pending empty.
  - o_valid_imemF = 0, o_en_fireF = 0, o_flag_killF = 0, o_flag_misalignF = 0.
  - o_addr_pcF = RESET_VECTOR, o_addr_pcadd4F = RESET_VECTOR+4.
- First request: o_valid_imemF rises in the 2nd cycle after reset release.
- Throughput: with ready high and no stall, one fetch per cycle; PC updates on the fire edge, latency 1.
- o_addr_pcadd4F, o_en_fireF and o_flag_killF are combinational from registered state and inputs. PC, state and pending are registered.
- Reset mid-request: the request is dropped immediately and the pending entry is lost.

## Structure
- Shared package arc_pkg:
  - typedef enum fetch_state_t {RST, RUN, HALT}
  - constant PC_INC = 32'd4
  - constant DEFAULT_RESET_VECTOR
- One natural sub-module: if_pcadd4, a 32-bit PC+4 incrementer that is the fetch-side counterpart of the EX branch adder.
- Everything else is flat: state FSM, PC register, pending valid and address registers, next-PC mux.

## Test plan
- Reset release with RESET_VECTOR=0, ready=1 → valid rises at cycle 2; fires fetch 0x0, 0x4, 0x8 on consecutive cycles; kill=0.
- PC=0x10, ready=0 for 3 cycles, branch to 0x200 in cycle 1 → o_addr_pcF holds 0x10; on fire, kill=1 and next PC=0x200; following fire has kill=0.
- Branch 0x300 and jump 0x400 in the same cycle, ready=1 → next PC=0x300. With 0x300 pending, a later jump 0x500 leaves pending at 0x300.
- Stall=1 with ready=1 for 2 cycles at PC=0x20 → no fire and PC=0x20; stall drops → fire and PC=0x24.
- Branch to 0x102 → o_flag_misalignF=1, valid=0; later jump to 0x40 → flag clears, fetch 0x40.
- PC=0xFFFF_FFFC → o_addr_pcadd4F=0x0, and the next sequential fetch is at 0x0.
